memory_writeback: RTL and testbench

Combined MEM and WB pipeline stage of the 5-stage MIPS core. It consumes the EX/MEM pipeline register and performs data-memory loads and stores against an internal word-addressed data memory with configurable access latency. It stalls upstream stages while an access is in flight, and holds the MEM/WB pipeline register. Its outputs drive the register-file write port of the decode stage.

---
 rtl/memory_writeback.sv | 109 ++++++++++
 tb/tb_memory_writeback.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/memory_writeback.sv
// Combined MEM/WB stage: word-addressed data memory access plus the MEM/WB register feeding the register file.
// Latency: 1 cycle for non-memory ops; MEM_LATENCY+1 cycles for loads/stores (commit in the final cycle).
// Backpressure: MemStall holds upstream while an access is in flight; MEM/WB takes bubbles meanwhile.
module memory_writeback #(
    parameter int MEM_WORDS   = 256,
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ExMemValid,
    input  logic [31:0] ExMemAluResult,
    input  logic [31:0] ExMemWriteData,
    input  logic [4:0]  ExMemWriteReg,
    input  logic        ExMemWriteRegEnable,
    input  logic        ExMemWriteMemoryEnable,
    input  logic        ExMemReadMemoryEnable,
    input  logic        ExMemwritebackRegCtrl,
    output logic        MemStall,
    output logic [31:0] writeData,
    output logic [4:0]  MemWBwritereg,
    output logic        WriteRegEnable
);

    localparam int         AW  = $clog2(MEM_WORDS);
    localparam logic [3:0] LAT = 4'(MEM_LATENCY);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;

    logic [31:0] mem [MEM_WORDS];
    logic [AW-1:0] word_addr;
    logic        mem_op;
    logic        commit;
    logic [31:0] load_data;
    logic        unused_addr_bits;

    // Byte offset and address bits above the memory depth are deliberately dropped.
    assign word_addr        = ExMemAluResult[AW+1:2];
    assign unused_addr_bits = ^{ExMemAluResult[31:AW+2], ExMemAluResult[1:0]};

    assign mem_op    = ExMemValid & (ExMemReadMemoryEnable | ExMemWriteMemoryEnable);
    // With MEM_LATENCY = 0 cnt never leaves 0, so the stall term is always false.
    assign MemStall  = mem_op & (cnt != LAT);
    assign commit    = mem_op & ~MemStall;
    // Read is taken before the commit edge, so a simultaneous store yields the old word.
    assign load_data = mem[word_addr];

    // FSM state and access counter; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state: IDLE launches an access, BUSY counts up to the commit cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (mem_op && (LAT != 4'd0)) begin
                    state_nxt = BUSY;
                    cnt_nxt   = 4'd1;
                end
            end
            BUSY: begin
                if (cnt < LAT) begin
                    cnt_nxt = cnt + 4'd1;
                end else begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Data memory store port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (commit && ExMemWriteMemoryEnable) begin
            mem[word_addr] <= ExMemWriteData;
        end
    end

    // MEM/WB register: bubbles during stalls and for invalid input, real result otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            writeData      <= 32'd0;
            MemWBwritereg  <= 5'd0;
            WriteRegEnable <= 1'b0;
        end else if (MemStall || !ExMemValid) begin
            WriteRegEnable <= 1'b0;
        end else begin
            writeData      <= ExMemwritebackRegCtrl ? load_data : ExMemAluResult;
            MemWBwritereg  <= ExMemWriteReg;
            WriteRegEnable <= ExMemWriteRegEnable & (ExMemWriteReg != 5'd0);
        end
    end

endmodule

// File: tb/tb_memory_writeback.sv
// Bench for memory_writeback: latency-2 and latency-0 instances sharing one stimulus bus.
// Expected MEM/WB contents are queued at issue and compared when the op commits.
// Stall pattern and bubble strobes are checked cycle by cycle.
module tb_memory_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [31:0] alu;
    logic [31:0] wdat;
    logic [4:0]  wreg;
    logic        wre;
    logic        mwe;
    logic        mre;
    logic        ctrl;

    logic        stall2, stall0;
    logic [31:0] data2, data0;
    logic [4:0]  reg2, reg0;
    logic        we2, we0;

    logic        sel;  // 0 = observe latency-2 instance, 1 = latency-0 instance
    logic        o_stall;
    logic [31:0] o_data;
    logic [4:0]  o_reg;
    logic        o_we;

    assign o_stall = sel ? stall0 : stall2;
    assign o_data  = sel ? data0  : data2;
    assign o_reg   = sel ? reg0   : reg2;
    assign o_we    = sel ? we0    : we2;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rg;
        logic        we;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    memory_writeback #(.MEM_WORDS(256), .MEM_LATENCY(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .ExMemValid(valid), .ExMemAluResult(alu),
        .ExMemWriteData(wdat), .ExMemWriteReg(wreg), .ExMemWriteRegEnable(wre),
        .ExMemWriteMemoryEnable(mwe), .ExMemReadMemoryEnable(mre),
        .ExMemwritebackRegCtrl(ctrl), .MemStall(stall2), .writeData(data2),
        .MemWBwritereg(reg2), .WriteRegEnable(we2)
    );

    memory_writeback #(.MEM_WORDS(256), .MEM_LATENCY(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .ExMemValid(valid), .ExMemAluResult(alu),
        .ExMemWriteData(wdat), .ExMemWriteReg(wreg), .ExMemWriteRegEnable(wre),
        .ExMemWriteMemoryEnable(mwe), .ExMemReadMemoryEnable(mre),
        .ExMemwritebackRegCtrl(ctrl), .MemStall(stall0), .writeData(data0),
        .MemWBwritereg(reg0), .WriteRegEnable(we0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] r, input logic re_g, input logic st,
                         input logic ld, input logic c);
        valid = v; alu = a; wdat = d; wreg = r; wre = re_g; mwe = st; mre = ld; ctrl = c;
    endtask

    // Issue one instruction, expect `stalls` stall cycles, then compare the committed MEM/WB value.
    task automatic op(input string tag, input logic v, input logic [31:0] a, input logic [31:0] d,
                      input logic [4:0] r, input logic re_g, input logic st, input logic ld,
                      input logic c, input int stalls, input logic [31:0] e_data,
                      input logic [4:0] e_reg, input logic e_we);
        exp_t e;
        drive(v, a, d, r, re_g, st, ld, c);
        e.data = e_data; e.rg = e_reg; e.we = e_we;
        exp_q.push_back(e);
        for (int cyc = 0; cyc <= stalls; cyc++) begin
            #1;
            chk({tag, "_stall"}, 32'(o_stall), 32'(cyc < stalls));
            @(posedge clk);
            #1;
            if (cyc < stalls) chk({tag, "_bubble_we"}, 32'(o_we), 32'd0);
        end
        e = exp_q.pop_front();
        chk({tag, "_data"}, o_data, e.data);
        chk({tag, "_reg"}, 32'(o_reg), 32'(e.rg));
        chk({tag, "_we"}, 32'(o_we), 32'(e.we));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        sel   = 1'b0;
        rst_n = 1'b0;
        // Reset with random payload but no valid instruction.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom));
            @(posedge clk);
            #1;
            chk("rst_stall", 32'(stall2), 32'd0);
            chk("rst_data", data2, 32'd0);
            chk("rst_reg", 32'(reg2), 32'd0);
            chk("rst_we", 32'(we2), 32'd0);
        end
        chk("rst_we0", 32'(we0), 32'd0);
        rst_n = 1'b1;

        // ALU op, then store/load round trip at latency 2 back to back.
        op("alu", 1, 32'h11, 32'h0, 5'd5, 1, 0, 0, 0, 0, 32'h11, 5'd5, 1);
        op("st40", 1, 32'h40, 32'hDEADBEEF, 5'd0, 0, 1, 0, 0, 2, 32'h40, 5'd0, 0);
        op("ld40", 1, 32'h40, 32'h0, 5'd9, 1, 0, 1, 1, 2, 32'hDEADBEEF, 5'd9, 1);
        op("wr_r0", 1, 32'h7, 32'h0, 5'd0, 1, 0, 0, 0, 0, 32'h7, 5'd0, 0);
        // Bubble with all enables set must not touch memory nor MEM/WB payload.
        op("bubble", 0, 32'h40, 32'h0, 5'd12, 1, 1, 1, 1, 0, 32'h7, 5'd0, 0);
        op("ld_unal", 1, 32'h43, 32'h0, 5'd4, 1, 0, 1, 1, 2, 32'hDEADBEEF, 5'd4, 1);
        op("ld_alias", 1, 32'h440, 32'h0, 5'd3, 1, 0, 1, 1, 2, 32'hDEADBEEF, 5'd3, 1);

        // Reset in the middle of a store: prior word survives and FSM restarts from IDLE.
        op("st80", 1, 32'h80, 32'hDEADBEEF, 5'd0, 0, 1, 0, 0, 2, 32'h80, 5'd0, 0);
        drive(1, 32'h80, 32'h12345678, 5'd0, 0, 1, 0, 0);
        @(posedge clk);
        #1;
        chk("midst_stall", 32'(stall2), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_data", data2, 32'd0);
        chk("midrst_we", 32'(we2), 32'd0);
        drive(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        op("ld80", 1, 32'h80, 32'h0, 5'd9, 1, 0, 1, 1, 2, 32'hDEADBEEF, 5'd9, 1);

        // Latency-0 instance: no stalls, store-to-load forwarding through memory, read-before-write.
        sel = 1'b1;
        op("z_st10", 1, 32'h10, 32'hA5A5A5A5, 5'd0, 0, 1, 0, 0, 0, 32'h10, 5'd0, 0);
        op("z_ld10", 1, 32'h10, 32'h0, 5'd7, 1, 0, 1, 1, 0, 32'hA5A5A5A5, 5'd7, 1);
        op("z_rmw", 1, 32'h10, 32'h5A5A5A5A, 5'd8, 1, 1, 1, 1, 0, 32'hA5A5A5A5, 5'd8, 1);
        op("z_ldnew", 1, 32'h10, 32'h0, 5'd10, 1, 0, 1, 1, 0, 32'h5A5A5A5A, 5'd10, 1);
        op("z_alu", 1, 32'hCAFE0001, 32'h0, 5'd31, 1, 0, 0, 0, 0, 32'hCAFE0001, 5'd31, 1);

        drive(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0);
        @(posedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
